// File: rtl/memb_feeder_pkg.sv
// Shared definitions for the memB feeder: element/array size defaults,
// the feeder state encoding and the drain-length helper.
package memb_feeder_pkg;

   localparam int BITS_AB_DEF = 8;
   localparam int DIM_DEF     = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } feed_state_e;

   // Zero rows needed after the last real row so the skewed systolic
   // array can flush every partial product out of its diagonal wavefront.
   function automatic int drain_len(input int dim);
      return 2 * dim - 1;
   endfunction

endpackage

// File: rtl/memb_feeder.sv
// memB feeder: buffers a DIM x DIM signed B matrix written row by row by the
// host, then streams it into the memB skew stage followed by a zero-filled
// drain so the systolic array can empty itself.
module memb_feeder
   import memb_feeder_pkg::*;
#(
   parameter int BITS_AB = BITS_AB_DEF,
   parameter int DIM     = DIM_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [$clog2(DIM)-1:0]    wr_row,
   input  logic [BITS_AB*DIM-1:0]    wr_data,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic                      memb_en,
   output logic signed [BITS_AB-1:0] Bout [DIM]
);

   localparam int RW = $clog2(DIM);
   localparam int CW = $clog2(2 * DIM);
   localparam logic [CW-1:0] LAST_ROW   = CW'(DIM - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(drain_len(DIM) - 1);

   feed_state_e stateQ, stateD;
   logic [CW-1:0] cntQ, cntD;
   logic [DIM-1:0] rowValidQ, rowValidD;
   logic errQ, errD;
   logic wrAccept;
   logic signed [BITS_AB-1:0] bufQ [DIM][DIM];

   // State, counter, valid mask and error pulse; the mask and error are
   // the only data-path state that reset must clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= ST_IDLE;
         cntQ      <= '0;
         rowValidQ <= '0;
         errQ      <= 1'b0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         rowValidQ <= rowValidD;
         errQ      <= errD;
      end
   end

   // Next-state logic: host writes only land in IDLE, and start is judged
   // against the mask as it stood before any coincident write.
   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      rowValidD = rowValidQ;
      errD      = 1'b0;
      wrAccept  = 1'b0;
      unique case (stateQ)
         ST_IDLE: begin
            if (wr_en) begin
               wrAccept          = 1'b1;
               rowValidD[wr_row] = 1'b1;
            end
            if (start) begin
               if (&rowValidQ) begin
                  stateD = ST_STREAM;
                  cntD   = '0;
               end else begin
                  errD = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            errD = wr_en;
            if (cntQ == LAST_ROW) begin
               stateD = ST_DRAIN;
               cntD   = '0;
            end else begin
               cntD = cntQ + CW'(1);
            end
         end
         ST_DRAIN: begin
            errD = wr_en;
            if (cntQ == LAST_DRAIN) begin
               stateD = ST_DONE;
               cntD   = '0;
            end else begin
               cntD = cntQ + CW'(1);
            end
         end
         ST_DONE: begin
            errD      = wr_en;
            rowValidD = '0;
            stateD    = ST_IDLE;
            cntD      = '0;
         end
         default: begin
            stateD = ST_IDLE;
            cntD   = '0;
         end
      endcase
   end

   // Matrix storage is deliberately left out of reset; rows are only
   // trusted once their valid bit is set.
   always_ff @(posedge clk) begin
      if (wrAccept) begin
         for (int j = 0; j < DIM; j++) begin
            bufQ[wr_row][j] <= wr_data[j*BITS_AB +: BITS_AB];
         end
      end
   end

   // Output decode: a buffered row while streaming, zeros otherwise.
   always_comb begin
      busy    = (stateQ == ST_STREAM) || (stateQ == ST_DRAIN);
      memb_en = busy;
      done    = (stateQ == ST_DONE);
      err     = errQ;
      for (int j = 0; j < DIM; j++) begin
         Bout[j] = '0;
         if (stateQ == ST_STREAM) begin
            Bout[j] = bufQ[cntQ[RW-1:0]][j];
         end
      end
   end

endmodule

// File: tb/tb_memb_feeder.sv
// Directed/randomized bench for memb_feeder with a timeline-based reference
// model of a run (position 1..3*DIM after an accepted start).
module tb_memb_feeder;

   localparam int B = 8;
   localparam int D = 8;
   localparam int RUN_LEN = D + (2 * D - 1) + 1;

   logic clk = 1'b0;
   logic rst_n;
   logic wr_en;
   logic [$clog2(D)-1:0] wr_row;
   logic [B*D-1:0] wr_data;
   logic start;
   logic busy, done, err, memb_en;
   logic signed [B-1:0] Bout [D];

   int vectors = 0;
   int miscompares = 0;

   logic signed [B-1:0] mBuf [D][D];
   logic [D-1:0] mValid;
   int runPos;
   logic expErr;
   int membCount;

   memb_feeder #(.BITS_AB(B), .DIM(D)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .memb_en (memb_en),
      .Bout    (Bout)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [B*D-1:0] randRow();
      return {$urandom, $urandom};
   endfunction

   task automatic checkEq(input string tag, input logic [B*D-1:0] obs, input logic [B*D-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model for one rising edge, using the inputs held across it.
   task automatic modelEdge();
      expErr = 1'b0;
      if (runPos == 0) begin
         if (start) begin
            if (&mValid) runPos = 1;
            else expErr = 1'b1;
         end
         if (wr_en) begin
            for (int j = 0; j < D; j++) mBuf[wr_row][j] = wr_data[j*B +: B];
            mValid[wr_row] = 1'b1;
         end
      end else begin
         if (wr_en) expErr = 1'b1;
         if (runPos == RUN_LEN) begin
            runPos = 0;
            mValid = '0;
         end else begin
            runPos++;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic expBusy;
      logic [B*D-1:0] expB, obsB;
      expBusy = (runPos >= 1) && (runPos < RUN_LEN);
      expB = '0;
      for (int j = 0; j < D; j++) begin
         obsB[j*B +: B] = Bout[j];
         if (runPos >= 1 && runPos <= D) expB[j*B +: B] = mBuf[runPos-1][j];
      end
      if (memb_en === 1'b1) membCount++;
      checkEq({tag, ".busy"}, {63'd0, busy}, {63'd0, expBusy});
      checkEq({tag, ".memb_en"}, {63'd0, memb_en}, {63'd0, expBusy});
      checkEq({tag, ".done"}, {63'd0, done}, {63'd0, runPos == RUN_LEN});
      checkEq({tag, ".err"}, {63'd0, err}, {63'd0, expErr});
      checkEq({tag, ".Bout"}, obsB, expB);
   endtask

   task automatic applyStimulus(input logic we, input int row, input logic [B*D-1:0] data,
                                input logic st, input string tag);
      wr_en   = we;
      wr_row  = row[$clog2(D)-1:0];
      wr_data = data;
      start   = st;
      @(posedge clk);
      modelEdge();
      #1;
      wr_en = 1'b0;
      start = 1'b0;
      checkOutput(tag);
   endtask

   task automatic fullRun(input string tag);
      membCount = 0;
      applyStimulus(1'b0, 0, '0, 1'b1, {tag, ".start"});
      repeat (RUN_LEN) applyStimulus(1'b0, 0, '0, 1'b0, tag);
      checkEq({tag, ".membCycles"}, 64'(membCount), 64'(2 * D - 1 + D));
   endtask

   initial begin
      logic [B*D-1:0] row0;
      rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; wr_row = '0; wr_data = '0;
      runPos = 0; mValid = '0; expErr = 1'b0; membCount = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] reset released");

      // Rows r = {r,...,r}, full run with 23 enabled cycles then done.
      for (int r = 0; r < D; r++) applyStimulus(1'b1, r, {D{8'(r)}}, 1'b0, "write031");
      fullRun("run031");

      // Incomplete mask: start rejected.
      for (int r = 0; r < D - 1; r++) applyStimulus(1'b1, r, randRow(), 1'b0, "write032");
      applyStimulus(1'b0, 0, '0, 1'b1, "start032");
      repeat (3) applyStimulus(1'b0, 0, '0, 1'b0, "idle032");

      // Start with a coincident last-row write sees the old mask.
      applyStimulus(1'b1, D - 1, randRow(), 1'b1, "startWithWrite");
      applyStimulus(1'b1, 2, randRow(), 1'b0, "overwriteRow2");

      // Write attempt during STREAM is rejected and row 3 keeps old data.
      applyStimulus(1'b0, 0, '0, 1'b1, "start033");
      applyStimulus(1'b1, 3, {D{8'h7F}}, 1'b0, "wrDuringStream");
      repeat (RUN_LEN - 1) applyStimulus(1'b0, 0, '0, 1'b0, "run033");

      // Back-to-back: mask cleared after done, rewrite and rerun.
      applyStimulus(1'b0, 0, '0, 1'b1, "startNoRewrite");
      for (int r = 0; r < D; r++) applyStimulus(1'b1, r, randRow(), 1'b0, "write036");
      fullRun("run036");

      // Signed extremes in row 0.
      row0 = randRow();
      row0[0*B +: B] = 8'h80;
      row0[1*B +: B] = 8'h7F;
      row0[2*B +: B] = 8'hFF;
      applyStimulus(1'b1, 0, row0, 1'b0, "write035");
      for (int r = 1; r < D; r++) applyStimulus(1'b1, r, randRow(), 1'b0, "write035");
      applyStimulus(1'b0, 0, '0, 1'b1, "start035");
      checkEq("signed0", 64'(signed'(Bout[0])), 64'(-128));
      checkEq("signed1", 64'(signed'(Bout[1])), 64'(127));
      checkEq("signed2", 64'(signed'(Bout[2])), 64'(-1));
      repeat (RUN_LEN) applyStimulus(1'b0, 0, '0, 1'b0, "run035");

      // Reset on STREAM cycle 4 aborts the run; stale rows are not trusted.
      for (int r = 0; r < D; r++) applyStimulus(1'b1, r, randRow(), 1'b0, "write034");
      applyStimulus(1'b0, 0, '0, 1'b1, "start034");
      repeat (3) applyStimulus(1'b0, 0, '0, 1'b0, "stream034");
      #2;
      rst_n = 1'b0;
      runPos = 0; mValid = '0; expErr = 1'b0;
      #1;
      checkOutput("midReset");
      @(posedge clk);
      #1;
      checkOutput("holdReset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 0, '0, 1'b1, "startAfterReset");
      applyStimulus(1'b0, 0, '0, 1'b0, "idleAfterReset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
